// File: rtl/alarm_sequencer.sv
// Alarm/chime sequencer: matches running time against the alarm and the top of the hour,
// and times ring, snooze and chime episodes in 1 Hz ticks for the downstream beep controller.
module alarm_sequencer #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int CHIME_SECONDS  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_armed,
    input  logic       chime_en,
    input  logic       key_stop,
    input  logic       key_snooze,
    output logic       beep,
    output logic       beep_enabled,
    output logic [1:0] state
);

    localparam int MAX_AB  = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
    localparam int MAX_SEC = (MAX_AB > CHIME_SECONDS) ? MAX_AB : CHIME_SECONDS;
    localparam int CW      = $clog2(MAX_SEC + 1);

    localparam logic [CW-1:0] RING_LD   = CW'(RING_SECONDS);
    localparam logic [CW-1:0] SNOOZE_LD = CW'(SNOOZE_SECONDS);
    localparam logic [CW-1:0] CHIME_LD  = CW'(CHIME_SECONDS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2,
        ST_CHIME   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          beep_q, beep_d;
    logic          beep_enabled_q, beep_enabled_d;
    logic          alarm_hit, chime_hit, sounding_d, expire;

    assign alarm_hit = tick_1hz && alarm_armed && (cur_hour == alarm_hour)
                       && (cur_min == alarm_min) && (cur_sec == 6'd0);
    assign chime_hit = tick_1hz && chime_en && (cur_min == 6'd0) && (cur_sec == 6'd0);
    assign expire    = tick_1hz && (cnt_q == CNT_ONE);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (alarm_hit) begin
                    state_d = ST_RINGING;
                    cnt_d   = RING_LD;
                end else if (chime_hit) begin
                    state_d = ST_CHIME;
                    cnt_d   = CHIME_LD;
                end
            end
            ST_RINGING: begin
                // Keys outrank a coincident tick, so stop on the last second is still a stop.
                if (!alarm_armed || key_stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (key_snooze) begin
                    state_d = ST_SNOOZE;
                    cnt_d   = SNOOZE_LD;
                end else if (expire) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (tick_1hz) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_SNOOZE: begin
                if (!alarm_armed || key_stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (expire) begin
                    state_d = ST_RINGING;
                    cnt_d   = RING_LD;
                end else if (tick_1hz) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_CHIME: begin
                if (expire) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (tick_1hz) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state, so beep and the first beep_enabled cycle
    // line up with the first cycle of the new state.
    always_comb begin
        sounding_d     = (state_d == ST_RINGING) || (state_d == ST_CHIME);
        beep_enabled_d = sounding_d;
        beep_d         = sounding_d && (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            beep_q         <= 1'b0;
            beep_enabled_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            beep_q         <= beep_d;
            beep_enabled_q <= beep_enabled_d;
        end
    end

    assign beep         = beep_q;
    assign beep_enabled = beep_enabled_q;
    assign state        = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with RING=5, SNOOZE=3, CHIME=2; inputs change and
// outputs are sampled on the falling clock edge.
module tb_alarm_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_armed;
    logic       chime_en;
    logic       key_stop;
    logic       key_snooze;
    logic       beep;
    logic       beep_enabled;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alarm_sequencer #(
        .RING_SECONDS  (5),
        .SNOOZE_SECONDS(3),
        .CHIME_SECONDS (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .cur_sec     (cur_sec),
        .alarm_hour  (alarm_hour),
        .alarm_min   (alarm_min),
        .alarm_armed (alarm_armed),
        .chime_en    (chime_en),
        .key_stop    (key_stop),
        .key_snooze  (key_snooze),
        .beep        (beep),
        .beep_enabled(beep_enabled),
        .state       (state)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int st, input int bp, input int be);
        check({tag, ".state"}, int'(state), st);
        check({tag, ".beep"}, int'(beep), bp);
        check({tag, ".beep_en"}, int'(beep_enabled), be);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one-cycle strobes starting at a falling edge; return on the next falling edge.
    task automatic pulse(input logic t, input logic stop, input logic snz);
        tick_1hz   = t;
        key_stop   = stop;
        key_snooze = snz;
        @(negedge clk);
        tick_1hz   = 1'b0;
        key_stop   = 1'b0;
        key_snooze = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            cyc(2);
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 5'(h);
        cur_min  = 6'(m);
        cur_sec  = 6'(s);
    endtask

    initial begin
        rst = 1'b1;
        tick_1hz = 1'b0; key_stop = 1'b0; key_snooze = 1'b0;
        alarm_armed = 1'b0; chime_en = 1'b0;
        alarm_hour = 5'd7; alarm_min = 6'd30;
        set_time(7, 29, 59);
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check_out("reset", 0, 0, 0);

        // Basic ring: 07:30 alarm, exactly 5 ticks of beep_enabled.
        alarm_armed = 1'b1;
        set_time(7, 30, 0);
        pulse(1'b1, 1'b0, 1'b0);
        set_time(7, 30, 1);
        check_out("ring_entry", 1, 1, 1);
        cyc(1);
        check_out("ring_beep_once", 1, 0, 1);
        ticks(4);
        check_out("ring_4_ticks", 1, 0, 1);
        ticks(1);
        check_out("ring_expired", 0, 0, 0);

        // Snooze after 2 ticks, re-ring after 3, then stop while snoozed.
        set_time(7, 30, 0);
        pulse(1'b1, 1'b0, 1'b0);
        set_time(7, 30, 1);
        check_out("ring2_entry", 1, 1, 1);
        ticks(2);
        pulse(1'b0, 1'b0, 1'b1);
        check_out("snooze_entry", 2, 0, 0);
        pulse(1'b0, 1'b0, 1'b1);
        check_out("snooze_key_ignored", 2, 0, 0);
        ticks(2);
        check_out("snooze_2_ticks", 2, 0, 0);
        pulse(1'b1, 1'b0, 1'b0);
        check_out("rering_entry", 1, 1, 1);
        cyc(1);
        ticks(4);
        check_out("rering_4_ticks", 1, 0, 1);
        pulse(1'b0, 1'b0, 1'b1);
        check_out("snooze2_entry", 2, 0, 0);
        pulse(1'b0, 1'b1, 1'b0);
        check_out("snooze_stop", 0, 0, 0);
        ticks(4);
        check_out("after_stop_quiet", 0, 0, 0);

        // Alarm beats a coincident chime; disarm drops ring; chime ignores keys.
        chime_en = 1'b1;
        alarm_hour = 5'd8; alarm_min = 6'd0;
        set_time(8, 0, 0);
        pulse(1'b1, 1'b0, 1'b0);
        set_time(8, 0, 1);
        check_out("alarm_over_chime", 1, 1, 1);
        alarm_armed = 1'b0;
        cyc(1);
        check_out("disarm_in_ring", 0, 0, 0);
        set_time(9, 0, 0);
        pulse(1'b1, 1'b0, 1'b0);
        set_time(9, 0, 1);
        check_out("chime_entry", 3, 1, 1);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        chime_en = 1'b0;
        cyc(1);
        check_out("chime_keys_ignored", 3, 0, 1);
        ticks(1);
        check_out("chime_1_tick", 3, 0, 1);
        ticks(1);
        check_out("chime_expired", 0, 0, 0);

        // key_stop coincident with the final tick.
        alarm_armed = 1'b1;
        alarm_hour = 5'd10; alarm_min = 6'd0;
        set_time(10, 0, 0);
        pulse(1'b1, 1'b0, 1'b0);
        set_time(10, 0, 1);
        check_out("ring3_entry", 1, 1, 1);
        ticks(4);
        check_out("ring3_cnt1", 1, 0, 1);
        pulse(1'b1, 1'b1, 1'b0);
        check_out("stop_and_tick", 0, 0, 0);

        // Reset mid-RINGING (in the beep cycle) and mid-SNOOZE.
        set_time(10, 0, 0);
        pulse(1'b1, 1'b0, 1'b0);
        set_time(10, 0, 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_out("rst_mid_ring", 0, 0, 0);
        ticks(6);
        check_out("rst_ring_no_rering", 0, 0, 0);
        set_time(10, 0, 0);
        pulse(1'b1, 1'b0, 1'b0);
        set_time(10, 0, 1);
        pulse(1'b0, 1'b0, 1'b1);
        check_out("snooze3_entry", 2, 0, 0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_out("rst_mid_snooze", 0, 0, 0);
        ticks(4);
        check_out("rst_snooze_no_rering", 0, 0, 0);

        // Near-misses: seconds not zero, or match without a tick.
        set_time(10, 0, 1);
        pulse(1'b1, 1'b0, 1'b0);
        check_out("sec1_no_hit", 0, 0, 0);
        set_time(10, 0, 0);
        cyc(4);
        check_out("no_tick_no_hit", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
